instr_sequencer: RTL

//  Instruction-issue side of the processor's DIN/Run/Done interface. Holds a small program

---
 rtl/instr_sequencer.sv | 80 ++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: issues a loaded program one word at a time over the DIN/Run/Done handshake.
module instr_sequencer #(
  parameter int DW      = 16,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          loop_en,
  input  logic          abort,
  input  logic          Done,
  output logic [DW-1:0] DIN,
  output logic          Run,
  output logic          busy,
  output logic          finished,
  output logic          err,
  output logic [AW-1:0] pc,
  output logic [15:0]   issued
);
  localparam int TW = $clog2(TIMEOUT) > 0 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;
  state_t state, state_nx;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] len;
  logic loop;
  logic [TW-1:0] wcnt;
  logic last, tmo, go;
  assign last = {1'b0, pc} == len - (AW+1)'(1);
  assign tmo = wcnt == TW'(TIMEOUT - 1);
  assign go = !abort && state == IDLE && start && prog_len != '0;
  assign busy = state == ISSUE || state == WAIT;
  assign Run = state == ISSUE && !abort;
  assign finished = state == FINISH;
  assign DIN = busy ? mem[pc] : '0;
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else case (state)
      IDLE:    state_nx = !start ? IDLE : (prog_len != '0 ? ISSUE : FINISH);
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = Done ? (last && !loop ? FINISH : ISSUE) : (tmo ? IDLE : WAIT);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clock)
    if (ld_en && state == IDLE) mem[ld_addr] <= ld_data;
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      state  <= IDLE;
      pc     <= '0;
      issued <= '0;
      err    <= 1'b0;
      len    <= '0;
      loop   <= 1'b0;
      wcnt   <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        pc     <= '0;
        issued <= '0;
        err    <= 1'b0;
        len    <= prog_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : prog_len;
        loop   <= loop_en;
      end
      if (state == ISSUE) wcnt <= '0;
      else if (state == WAIT && !Done) wcnt <= wcnt + TW'(1);
      // a wrapped run restarts at word 0; a normal run keeps the last index for inspection
      if (!abort && state == WAIT && Done) begin
        issued <= issued + 16'd1;
        pc     <= last ? (loop ? '0 : pc) : pc + AW'(1);
      end
      if (!abort && state == WAIT && !Done && tmo) err <= 1'b1;
    end
endmodule
